// File: rtl/dot_accum_pkg.sv
// Shared types and helpers for the dot-product accumulator.
// Optional feature macro: SATURATE_EN (saturating accumulation + overflow flag).
package dot_accum_pkg;

    // ST_ACC collects products, ST_OUT presents one finished result
    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    // Product counter width; a single-product group still needs a 1-bit counter
    function automatic int cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    localparam int LEN_DEF = 4;
    localparam int CNT_W   = cnt_width(LEN_DEF);

endpackage

// File: rtl/dot_prod_accum_sat_add.sv
// ACC_W-wide adder with carry-out; clamps to all-ones on carry when SATURATE_EN is defined.
module sat_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] full;

    // One extra bit exposes the carry used for clamping and the sticky flag
    always_comb begin
        full = {1'b0, a} + {1'b0, b};
        cout = full[W];
`ifdef SATURATE_EN
        sum  = cout ? '1 : full[W-1:0];
`else
        sum  = full[W-1:0];
`endif
    end

endmodule

// File: rtl/dot_prod_accum.sv
// Sums LEN multiplier products into one dot product, presented on a valid/ready port.
// Optional feature macro: SATURATE_EN (clamp on overflow, sticky dot_ovf per result).
module dot_prod_accum
    import dot_accum_pkg::*;
#(
    parameter int PROD_W = 4,
    parameter int ACC_W  = 8,
    parameter int LEN    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  dot_out,
    output logic              dot_valid,
    input  logic              dot_ready,
    output logic              dot_ovf
);

    localparam int CW = cnt_width(LEN);

    if (LEN < 1 || ACC_W < PROD_W) begin : g_param_chk
        $error("dot_prod_accum: need LEN >= 1 and ACC_W >= PROD_W");
    end

    state_t          state, state_nxt;
    logic [ACC_W-1:0] acc, sum;
    logic [CW-1:0]    cnt;
    logic             cout;
    logic             in_hs, last;

    assign in_hs = prod_valid && prod_ready;
    assign last  = (cnt == CW'(LEN - 1));

    sat_add #(.W(ACC_W)) u_add (
        .a    (acc),
        .b    (ACC_W'(prod_in)),
        .sum  (sum),
        .cout (cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_ACC;
        else     state <= state_nxt;
    end

    // Next state: leave ST_ACC on the group's last product, return on result handshake
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC: if (in_hs && last) state_nxt = ST_OUT;
            ST_OUT: if (dot_ready)     state_nxt = ST_ACC;
            default:                   state_nxt = ST_ACC;
        endcase
    end

    // Input ready decoded from registered state only, no path from dot_ready
    always_comb begin
        prod_ready = (state == ST_ACC);
    end

    // Accumulator, counter and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            dot_out   <= '0;
            dot_valid <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (in_hs) begin
                        if (last) begin
                            dot_out   <= sum;
                            dot_valid <= 1'b1;
                            acc       <= '0;
                            cnt       <= '0;
                        end else begin
                            acc <= sum;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_OUT: if (dot_ready) dot_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef SATURATE_EN
    logic ovf_grp;

    // Sticky per-group overflow, handed to dot_ovf together with the result
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_grp <= 1'b0;
            dot_ovf <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (in_hs) begin
                        if (last) begin
                            dot_ovf <= ovf_grp | cout;
                            ovf_grp <= 1'b0;
                        end else begin
                            ovf_grp <= ovf_grp | cout;
                        end
                    end
                end
                ST_OUT: if (dot_ready) dot_ovf <= 1'b0;
                default: ;
            endcase
        end
    end
`else
    logic unused_cout;
    assign unused_cout = cout;
    assign dot_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_dot_prod_accum.sv
// Randomized + directed bench for dot_prod_accum: an 8-bit and a 5-bit accumulator
// instance share stimulus and are checked against a queue-based group-sum model.
module tb_dot_prod_accum;

    localparam int LEN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] prod_in = '0;
    logic       prod_valid = 1'b0;
    logic       dot_ready = 1'b0;

    logic       prod_ready8, dot_valid8, dot_ovf8;
    logic [7:0] dot_out8;
    logic       prod_ready5, dot_valid5, dot_ovf5;
    logic [4:0] dot_out5;

    always #5 clk = ~clk;

    dot_prod_accum #(.PROD_W(4), .ACC_W(8), .LEN(LEN)) u_dut8 (
        .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
        .prod_ready(prod_ready8), .dot_out(dot_out8), .dot_valid(dot_valid8),
        .dot_ready(dot_ready), .dot_ovf(dot_ovf8)
    );

    dot_prod_accum #(.PROD_W(4), .ACC_W(5), .LEN(LEN)) u_dut5 (
        .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
        .prod_ready(prod_ready5), .dot_out(dot_out5), .dot_valid(dot_valid5),
        .dot_ready(dot_ready), .dot_ovf(dot_ovf5)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: products of the open group, plus the result on display
    int q[$];
    bit busy = 0;
    int exp_out8 = 0, exp_out5 = 0;
    bit exp_ovf8 = 0, exp_ovf5 = 0;

    // Group result in a w-bit accumulator: wrap, or clamp-and-flag when saturating
    function automatic int group_sum(input int w, output bit ovf);
        int maxv = (1 << w) - 1;
        int s = 0;
        ovf = 0;
        foreach (q[i]) begin
`ifdef SATURATE_EN
            if (s + q[i] > maxv) begin s = maxv; ovf = 1; end
            else s = s + q[i];
`else
            s = (s + q[i]) & maxv;
`endif
        end
        return s;
    endfunction

    task automatic step(input bit r, input bit pv, input logic [3:0] p, input bit d, input string tag);
        @(negedge clk);
        rst = r; prod_valid = pv; prod_in = p; dot_ready = d;
        if (r) begin
            q.delete(); busy = 0;
            exp_out8 = 0; exp_out5 = 0; exp_ovf8 = 0; exp_ovf5 = 0;
        end else if (!busy) begin
            if (pv) begin
                q.push_back(int'(p));
                if (q.size() == LEN) begin
                    exp_out8 = group_sum(8, exp_ovf8);
                    exp_out5 = group_sum(5, exp_ovf5);
                    busy = 1;
                    q.delete();
                end
            end
        end else if (d) begin
            busy = 0; exp_ovf8 = 0; exp_ovf5 = 0;
        end
        @(posedge clk); #1;
        chk({tag, ".valid8"}, 32'(dot_valid8), 32'(busy));
        chk({tag, ".ready8"}, 32'(prod_ready8), 32'(!busy));
        chk({tag, ".out8"},   32'(dot_out8), 32'(exp_out8));
        chk({tag, ".ovf8"},   32'(dot_ovf8), 32'(exp_ovf8));
        chk({tag, ".valid5"}, 32'(dot_valid5), 32'(busy));
        chk({tag, ".ready5"}, 32'(prod_ready5), 32'(!busy));
        chk({tag, ".out5"},   32'(dot_out5), 32'(exp_out5));
        chk({tag, ".ovf5"},   32'(dot_ovf5), 32'(exp_ovf5));
    endtask

    initial begin
        // Reset for two cycles
        step(1, 0, 0, 0, "rst");
        step(1, 1, 4'd7, 0, "rst");
        step(0, 0, 0, 0, "idle");

        // 1,2,3,9 back-to-back with sink ready -> 15
        step(0, 1, 4'd1, 1, "g1");
        step(0, 1, 4'd2, 1, "g1");
        step(0, 1, 4'd3, 1, "g1");
        step(0, 1, 4'd9, 1, "g1");
        step(0, 0, 0, 1, "g1.pop");

        // Same group, sink stalled 5 cycles while products are offered and ignored
        step(0, 1, 4'd1, 0, "g2");
        step(0, 1, 4'd2, 0, "g2");
        step(0, 1, 4'd3, 0, "g2");
        step(0, 1, 4'd9, 0, "g2");
        for (int i = 0; i < 5; i++) step(0, 1, 4'd7, 0, "g2.stall");
        step(0, 0, 0, 1, "g2.pop");
        for (int i = 0; i < 4; i++) step(0, 1, 4'd1, 1, "g3");
        step(0, 0, 0, 1, "g3.pop");

        // 9s every other cycle; idle-cycle data is garbage and must be ignored
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 4'd9, 0, "g4");
            step(0, 0, 4'hF, 0, "g4.idle");
        end
        step(0, 0, 0, 1, "g4.pop");

        // Aborted group: 9,9 then reset (with a product offered), then 1,1,1,1 -> 4
        step(0, 1, 4'd9, 1, "g5");
        step(0, 1, 4'd9, 1, "g5");
        step(1, 1, 4'd9, 1, "g5.rst");
        for (int i = 0; i < 4; i++) step(0, 1, 4'd1, 1, "g5b");
        step(0, 0, 0, 1, "g5b.pop");

        // Reset while a result is pending drops it
        for (int i = 0; i < 4; i++) step(0, 1, 4'd15, 0, "g6");
        step(1, 0, 0, 0, "g6.rst");
        step(0, 0, 0, 0, "g6.idle");

        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
                 4'($urandom), bit'($urandom_range(0, 1)), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
